// File: rtl/aes_pkg.sv
// Shared constants and helpers for the AES round scheduler and its SPI-side driver.
// Optional key-reuse support is enabled with AES_SCHED_KEY_REUSE_EN.
package aes_pkg;

  localparam logic [2:0] StIdle  = 3'd0;
  localparam logic [2:0] StKexp  = 3'd1;
  localparam logic [2:0] StLoad  = 3'd2;
  localparam logic [2:0] StRound = 3'd3;
  localparam logic [2:0] StFinal = 3'd4;
  localparam logic [2:0] StDone  = 3'd5;

  localparam logic [7:0] KeyLen128 = 8'd16;
  localparam logic [7:0] KeyLen192 = 8'd24;
  localparam logic [7:0] KeyLen256 = 8'd32;

  localparam logic [3:0] Nk128 = 4'd4;
  localparam logic [3:0] Nk192 = 4'd6;
  localparam logic [3:0] Nk256 = 4'd8;
  localparam logic [3:0] Nr128 = 4'd10;
  localparam logic [3:0] Nr192 = 4'd12;
  localparam logic [3:0] Nr256 = 4'd14;

  typedef struct packed {
    logic busy;
    logic done;
    logic err;
    logic ks_en;
    logic load_state;
    logic rnd_en;
    logic rnd_last;
  } sched_flags_t;

  // Returns 0 for an unsupported key length.
  function automatic logic [3:0] nr_of_key_len(input logic [7:0] key_len);
    case (key_len)
      KeyLen128: nr_of_key_len = Nr128;
      KeyLen192: nr_of_key_len = Nr192;
      KeyLen256: nr_of_key_len = Nr256;
      default:   nr_of_key_len = 4'd0;
    endcase
  endfunction

endpackage

// File: rtl/aes_round_scheduler_if.sv
// Driver <-> scheduler handshake and datapath control bundle.
// key_reuse exists only when AES_SCHED_KEY_REUSE_EN is defined.
interface aes_round_scheduler_if #(
  parameter int unsigned MAX_NK = 8
);
  localparam int unsigned WordW = $clog2(4 * (MAX_NK + 7));
  localparam int unsigned RndW  = $clog2(MAX_NK + 7);

  logic             start;
  logic             mode;
  logic [7:0]       key_len;
`ifdef AES_SCHED_KEY_REUSE_EN
  logic             key_reuse;
`endif
  logic             busy;
  logic             done;
  logic             err;
  logic             ks_en;
  logic [WordW-1:0] ks_word_idx;
  logic             load_state;
  logic             rnd_en;
  logic             rnd_last;
  logic [RndW-1:0]  round_idx;

  modport master (
`ifdef AES_SCHED_KEY_REUSE_EN
    output key_reuse,
`endif
    output start, mode, key_len,
    input  busy, done, err, ks_en, ks_word_idx, load_state, rnd_en, rnd_last, round_idx
  );

  modport slave (
`ifdef AES_SCHED_KEY_REUSE_EN
    input  key_reuse,
`endif
    input  start, mode, key_len,
    output busy, done, err, ks_en, ks_word_idx, load_state, rnd_en, rnd_last, round_idx
  );

endinterface

// File: rtl/aes_keylen_decode.sv
// Combinational key-length byte decode to {valid, Nk, Nr}; shared with the driver.
module aes_keylen_decode
  import aes_pkg::*;
(
  input  logic [7:0] key_len,
  output logic       valid,
  output logic [3:0] nk,
  output logic [3:0] nr
);

  always_comb begin
    valid = 1'b1;
    nr    = nr_of_key_len(key_len);
    case (key_len)
      KeyLen128: nk = Nk128;
      KeyLen192: nk = Nk192;
      KeyLen256: nk = Nk256;
      default: begin
        nk    = 4'd0;
        valid = 1'b0;
      end
    endcase
  end

endmodule

// File: rtl/aes_round_scheduler.sv
// Control FSM sequencing key expansion, initial AddRoundKey and Nr rounds of a shared AES core.
// Define AES_SCHED_KEY_REUSE_EN to allow skipping key expansion for a repeated key.
module aes_round_scheduler
  import aes_pkg::*;
#(
  parameter int unsigned MAX_NK = 8
) (
  input logic                  clk,
  input logic                  reset,
  aes_round_scheduler_if.slave bus
);

  localparam int unsigned WordW = $clog2(4 * (MAX_NK + 7));
  localparam int unsigned RndW  = $clog2(MAX_NK + 7);

  logic [2:0]       state_q, state_d;
  logic [WordW-1:0] widx_q, widx_d, last_word;
  logic [RndW-1:0]  ridx_q, ridx_d, nr_idx;
  logic [3:0]       nr_q;
  logic             mode_q;
  logic             accept, err_d, reuse_hit;
  logic             dec_valid;
  logic [3:0]       dec_nk, dec_nr;
  sched_flags_t     flags_q, flags_d;

  aes_keylen_decode u_decode (
    .key_len (bus.key_len),
    .valid   (dec_valid),
    .nk      (dec_nk),
    .nr      (dec_nr)
  );

  // Last expanded word index is 4*(Nr+1)-1.
  assign last_word = WordW'({nr_q, 2'b00}) + WordW'(3);
  assign nr_idx    = RndW'(nr_q);

`ifdef AES_SCHED_KEY_REUSE_EN
  logic       key_valid_q;
  logic [7:0] key_len_q;

  assign reuse_hit = bus.key_reuse && key_valid_q && (bus.key_len == key_len_q);

  // A fresh expansion overwrites the key store, so validity returns only at its DONE.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      key_valid_q <= 1'b0;
      key_len_q   <= 8'd0;
    end else begin
      if (accept && !reuse_hit) begin
        key_valid_q <= 1'b0;
      end else if (state_d == StDone) begin
        key_valid_q <= 1'b1;
      end
      if (accept) begin
        key_len_q <= bus.key_len;
      end
    end
  end
`else
  assign reuse_hit = 1'b0;
`endif

  always_comb begin
    state_d = state_q;
    widx_d  = '0;
    ridx_d  = '0;
    accept  = 1'b0;
    err_d   = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (bus.start) begin
          if (dec_valid) begin
            accept = 1'b1;
            if (reuse_hit) begin
              state_d = StLoad;
              ridx_d  = bus.mode ? RndW'(dec_nr) : '0;
            end else begin
              state_d = StKexp;
              widx_d  = WordW'(dec_nk);
            end
          end else begin
            err_d = 1'b1;
          end
        end
      end
      StKexp: begin
        if (widx_q == last_word) begin
          state_d = StLoad;
          ridx_d  = mode_q ? nr_idx : '0;
        end else begin
          widx_d = widx_q + WordW'(1);
        end
      end
      StLoad: begin
        state_d = StRound;
        ridx_d  = mode_q ? nr_idx - RndW'(1) : RndW'(1);
      end
      StRound: begin
        if (mode_q ? (ridx_q == RndW'(1)) : (ridx_q == nr_idx - RndW'(1))) begin
          state_d = StFinal;
          ridx_d  = mode_q ? '0 : nr_idx;
        end else begin
          ridx_d = mode_q ? ridx_q - RndW'(1) : ridx_q + RndW'(1);
        end
      end
      StFinal: state_d = StDone;
      StDone:  state_d = StIdle;
      default: state_d = StIdle;
    endcase

    // Flags are derived from the next state so every output leaves a flop.
    flags_d.busy       = (state_d != StIdle);
    flags_d.done       = (state_d == StDone);
    flags_d.err        = err_d;
    flags_d.ks_en      = (state_d == StKexp);
    flags_d.load_state = (state_d == StLoad);
    flags_d.rnd_en     = (state_d == StRound) || (state_d == StFinal);
    flags_d.rnd_last   = (state_d == StFinal);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= StIdle;
      widx_q  <= '0;
      ridx_q  <= '0;
      nr_q    <= 4'd0;
      mode_q  <= 1'b0;
      flags_q <= '0;
    end else begin
      state_q <= state_d;
      widx_q  <= widx_d;
      ridx_q  <= ridx_d;
      flags_q <= flags_d;
      if (accept) begin
        nr_q   <= dec_nr;
        mode_q <= bus.mode;
      end
    end
  end

  assign bus.busy        = flags_q.busy;
  assign bus.done        = flags_q.done;
  assign bus.err         = flags_q.err;
  assign bus.ks_en       = flags_q.ks_en;
  assign bus.ks_word_idx = widx_q;
  assign bus.load_state  = flags_q.load_state;
  assign bus.rnd_en      = flags_q.rnd_en;
  assign bus.rnd_last    = flags_q.rnd_last;
  assign bus.round_idx   = ridx_q;

endmodule

// File: tb/tb_aes_round_scheduler.sv
// Self-checking bench for aes_round_scheduler: table of key sizes/modes plus abort and busy cases.
// Exercises key reuse as well when AES_SCHED_KEY_REUSE_EN is defined.
module tb_aes_round_scheduler;

  logic clk   = 1'b0;
  logic reset = 1'b0;
  int   n_tests = 0;
  int   n_fail  = 0;

  always #5 clk = ~clk;

  aes_round_scheduler_if #(.MAX_NK(8)) bus ();

  aes_round_scheduler #(.MAX_NK(8)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  typedef struct {
    logic [7:0] kl;
    logic       md;
    bit         valid;
    int         nk;
    int         nr;
    int         lat;
  } vec_t;

  vec_t vecs[9];

  // {busy, done, err, ks_en, ks_word_idx[5:0], load_state, rnd_en, rnd_last, round_idx[3:0]}
  function automatic logic [16:0] obs();
    return {bus.busy, bus.done, bus.err, bus.ks_en, bus.ks_word_idx,
            bus.load_state, bus.rnd_en, bus.rnd_last, bus.round_idx};
  endfunction

  // Expected outputs c cycles after the accepting edge (c=0 is the first cycle after it).
  function automatic logic [16:0] exp_at(int c, logic md, int nk, int nr, bit skip);
    int         k    = skip ? 0 : 4 * (nr + 1) - nk;
    logic       busy = 1'b0, done = 1'b0, ks = 1'b0, ld = 1'b0, re = 1'b0, last = 1'b0;
    logic [5:0] w    = 6'd0;
    logic [3:0] r    = 4'd0;
    if (c < k) begin
      busy = 1'b1; ks = 1'b1; w = 6'(nk + c);
    end else if (c == k) begin
      busy = 1'b1; ld = 1'b1; r = md ? 4'(nr) : 4'd0;
    end else if (c < k + nr) begin
      busy = 1'b1; re = 1'b1; r = md ? 4'(nr - (c - k)) : 4'(c - k);
    end else if (c == k + nr) begin
      busy = 1'b1; re = 1'b1; last = 1'b1; r = md ? 4'd0 : 4'(nr);
    end else if (c == k + nr + 1) begin
      busy = 1'b1; done = 1'b1;
    end
    return {busy, done, 1'b0, ks, w, ld, re, last, r};
  endfunction

  task automatic check(input string name, input int c, input logic [16:0] want);
    logic [16:0] got;
    got = obs();
    n_tests++;
    if (got !== want) begin
      n_fail++;
      $display("FAIL %s cycle %0d: got %h want %h", name, c, got, want);
    end
  endtask

  task automatic check_int(input string name, input int got, input int want);
    n_tests++;
    if (got != want) begin
      n_fail++;
      $display("FAIL %s: got %0d want %0d", name, got, want);
    end
  endtask

  // One start; disturb toggles start/key_len/mode while busy (incl. the DONE cycle);
  // abort_at >= 0 pulls reset at that cycle and watches for a silent return to idle.
  task automatic run_op(input string name, input logic [7:0] kl, input logic md, input int nk,
                        input int nr, input int lat, input bit reuse, input bit skip,
                        input bit disturb, input int abort_at);
    int done_at = -1;
    int span    = (skip ? 0 : 4 * (nr + 1) - nk) + nr + 2;
    @(negedge clk);
    bus.start   = 1'b1;
    bus.key_len = kl;
    bus.mode    = md;
`ifdef AES_SCHED_KEY_REUSE_EN
    bus.key_reuse = reuse;
`endif
    for (int c = 0; c <= span; c++) begin
      @(posedge clk);
      #1;
      check(name, c, exp_at(c, md, nk, nr, skip));
      if (bus.done && done_at < 0) done_at = c;
      if (disturb && c < span) begin
        bus.start   = (c % 2 == 1) || (c == span - 1);
        bus.key_len = 8'd16;
        bus.mode    = ~md;
      end else begin
        bus.start = 1'b0;
      end
      if (c == abort_at) begin
        #1 reset = 1'b0;
        #1 check({name, "_rst_now"}, c, 17'h0);
        @(negedge clk);
        check({name, "_rst_hold"}, c, 17'h0);
        reset = 1'b1;
        for (int i = 0; i < 20; i++) begin
          @(posedge clk);
          #1 check({name, "_post_abort"}, i, 17'h0);
        end
        break;
      end
    end
    bus.start = 1'b0;
`ifdef AES_SCHED_KEY_REUSE_EN
    bus.key_reuse = 1'b0;
`endif
    if (abort_at < 0) check_int({name, "_latency"}, done_at, lat);
  endtask

  task automatic run_err(input string name, input logic [7:0] kl);
    @(negedge clk);
    bus.start   = 1'b1;
    bus.key_len = kl;
    @(posedge clk);
    #1 bus.start = 1'b0;
    check(name, 0, 17'h04000);
    for (int c = 1; c < 3; c++) begin
      @(posedge clk);
      #1 check(name, c, 17'h0);
    end
  endtask

  initial begin
    vecs[0] = '{kl: 8'd16, md: 1'b0, valid: 1'b1, nk: 4, nr: 10, lat: 51};
    vecs[1] = '{kl: 8'd32, md: 1'b1, valid: 1'b1, nk: 8, nr: 14, lat: 67};
    vecs[2] = '{kl: 8'd20, md: 1'b0, valid: 1'b0, nk: 0, nr: 0,  lat: 0};
    vecs[3] = '{kl: 8'd24, md: 1'b0, valid: 1'b1, nk: 6, nr: 12, lat: 59};
    vecs[4] = '{kl: 8'd16, md: 1'b1, valid: 1'b1, nk: 4, nr: 10, lat: 51};
    vecs[5] = '{kl: 8'd24, md: 1'b1, valid: 1'b1, nk: 6, nr: 12, lat: 59};
    vecs[6] = '{kl: 8'd32, md: 1'b0, valid: 1'b1, nk: 8, nr: 14, lat: 67};
    vecs[7] = '{kl: 8'd0,  md: 1'b0, valid: 1'b0, nk: 0, nr: 0,  lat: 0};
    vecs[8] = '{kl: 8'd33, md: 1'b1, valid: 1'b0, nk: 0, nr: 0,  lat: 0};

    bus.start   = 1'b0;
    bus.mode    = 1'b0;
    bus.key_len = 8'd0;
`ifdef AES_SCHED_KEY_REUSE_EN
    bus.key_reuse = 1'b0;
`endif
    repeat (2) @(posedge clk);
    #1 check("reset_state", 0, 17'h0);
    @(negedge clk);
    reset = 1'b1;
    @(posedge clk);
    #1 check("idle_after_reset", 0, 17'h0);

    for (int i = 0; i < 9; i++) begin
      if (vecs[i].valid) begin
        run_op($sformatf("vec%0d", i), vecs[i].kl, vecs[i].md, vecs[i].nk, vecs[i].nr,
               vecs[i].lat, 1'b0, 1'b0, 1'b0, -1);
      end else begin
        run_err($sformatf("vec%0d_err", i), vecs[i].kl);
      end
    end

    run_op("busy_ignore", 8'd24, 1'b0, 6, 12, 59, 1'b0, 1'b0, 1'b1, -1);
    // 5th ROUND cycle for a 128-bit key is c = 40 + 5.
    run_op("abort", 8'd16, 1'b0, 4, 10, 51, 1'b0, 1'b0, 1'b0, 45);
`ifdef AES_SCHED_KEY_REUSE_EN
    run_op("reuse_after_reset", 8'd16, 1'b0, 4, 10, 51, 1'b1, 1'b0, 1'b0, -1);
    run_op("reuse_hit", 8'd16, 1'b0, 4, 10, 11, 1'b1, 1'b1, 1'b0, -1);
    run_op("reuse_other_len", 8'd24, 1'b1, 6, 12, 59, 1'b1, 1'b0, 1'b0, -1);
`else
    run_op("after_abort", 8'd16, 1'b0, 4, 10, 51, 1'b0, 1'b0, 1'b0, -1);
`endif

    @(posedge clk);
    #1 check("final_idle", 0, 17'h0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
